exec_state_writeback_buffer: RTL and testbench

//  Producer side of the active-list execution-state interface read at commit.

---
 rtl/exec_state_writeback_buffer.sv | 175 +++++++++++++++++
 tb/tb_exec_state_writeback_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_state_writeback_buffer.sv
// ---------------------------------------------------------------------------
// exec_state_writeback_buffer
//
// Producer side of the active-list execution-state interface. Finished-op
// reports (active-list index + ExecutionState) arrive on IN_LANES writeback
// lanes. They are compacted in lane order, with lane 0 treated as oldest, and
// buffered in a DEPTH-entry circular FIFO. Up to WR_PORTS entries per cycle
// are then written into the active-list exec-state table, oldest first.
//
// Optional feature macro: EXEC_STATE_BYPASS_EN
//   When this macro is defined and the FIFO is empty (and no flush is
//   active), up to WR_PORTS accepted reports drive the write ports in the
//   same cycle. Any remaining valid lanes are enqueued.
//   When the macro is undefined, every report passes through the FIFO.
//
// Handshake
//   A lane report is taken when in_valid[l] && in_ready && !flush.
//   in_ready depends on the registered count only, so it is stable for the
//   whole cycle. An offer made while in_ready is low is dropped, and the
//   sticky ovf_err flag is set. There is no back-pressure on the write
//   ports: the active list accepts every write.
//
// Ports
//   clk       in   clock
//   rst       in   asynchronous, active-low reset
//   flush     in   synchronous recovery flush; drops all buffered and
//                  same-cycle reports
//   in_valid  in   [IN_LANES]            report valid per lane
//   in_ptr    in   [IN_LANES*AL_IDX_W]   active-list index per lane
//   in_state  in   [IN_LANES*STATE_W]    ExecutionState per lane
//   in_ready  out  all lanes may report this cycle
//   wr_valid  out  [WR_PORTS]            write enable per port
//   wr_ptr    out  [WR_PORTS*AL_IDX_W]   active-list index per port
//   wr_state  out  [WR_PORTS*STATE_W]    state written per port
//   count     out  [$clog2(DEPTH)+1]     occupied entries (registered)
//   ovf_err   out  sticky: a report was offered while in_ready was low
// ---------------------------------------------------------------------------
module exec_state_writeback_buffer #(
    parameter int IN_LANES = 4,
    parameter int WR_PORTS = 2,
    parameter int DEPTH    = 8,
    parameter int AL_IDX_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [IN_LANES-1:0]           in_valid,
    input  logic [IN_LANES*AL_IDX_W-1:0]  in_ptr,
    input  logic [IN_LANES*STATE_W-1:0]   in_state,
    output logic                          in_ready,
    output logic [WR_PORTS-1:0]           wr_valid,
    output logic [WR_PORTS*AL_IDX_W-1:0]  wr_ptr,
    output logic [WR_PORTS*STATE_W-1:0]   wr_state,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          ovf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(IN_LANES);
    localparam logic [CW-1:0] WR_C    = CW'(WR_PORTS);

    logic [AL_IDX_W-1:0] ptr_mem [DEPTH];
    logic [STATE_W-1:0]  st_mem  [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    // pos[l] is the rank of lane l among the valid lanes. It gives the
    // compacted slot of that lane relative to tail, or its bypass port.
    logic [CW-1:0] pos [IN_LANES];
    logic [CW-1:0] n_valid;
    logic [CW-1:0] byp_n;
    logic [CW-1:0] enq_n;
    logic [CW-1:0] deq_n;
    logic          accept;
`ifdef EXEC_STATE_BYPASS_EN
    logic          byp_act;
`endif

    always_comb begin
        in_ready = (DEPTH_C - count_q) >= LANES_C;
        accept   = in_ready && !flush;

        n_valid = '0;
        for (int l = 0; l < IN_LANES; l++) begin
            pos[l] = n_valid;
            if (in_valid[l]) begin
                n_valid = n_valid + 1'b1;
            end
        end

`ifdef EXEC_STATE_BYPASS_EN
        // An empty FIFO always implies in_ready, so bypassed lanes are
        // always accepted lanes.
        byp_act = (count_q == '0) && !flush;
        byp_n   = byp_act ? ((n_valid > WR_C) ? WR_C : n_valid) : '0;
`else
        byp_n   = '0;
`endif

        enq_n = accept ? (n_valid - byp_n) : '0;
        deq_n = flush ? '0 : ((count_q > WR_C) ? WR_C : count_q);

        // Port k drains entry head+k while that entry exists.
        // A flush suppresses all writes in the same cycle.
        wr_valid = '0;
        wr_ptr   = '0;
        wr_state = '0;
        for (int k = 0; k < WR_PORTS; k++) begin
            wr_valid[k]                      = !flush && (CW'(k) < count_q);
            wr_ptr[k*AL_IDX_W +: AL_IDX_W]   = ptr_mem[head_q + PW'(k)];
            wr_state[k*STATE_W +: STATE_W]   = st_mem[head_q + PW'(k)];
        end

`ifdef EXEC_STATE_BYPASS_EN
        // With an empty FIFO no port is in use, so the oldest valid lanes
        // take ports 0..byp_n-1 directly.
        for (int k = 0; k < WR_PORTS; k++) begin
            for (int l = 0; l < IN_LANES; l++) begin
                if (byp_act && in_valid[l] && (pos[l] == CW'(k))) begin
                    wr_valid[k]                    = 1'b1;
                    wr_ptr[k*AL_IDX_W +: AL_IDX_W] = in_ptr[l*AL_IDX_W +: AL_IDX_W];
                    wr_state[k*STATE_W +: STATE_W] = in_state[l*STATE_W +: STATE_W];
                end
            end
        end
`endif

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(deq_n);
            tail_d  = tail_q + PW'(enq_n);
            count_d = count_q + enq_n - deq_n;
        end

        ovf_d = ovf_q || ((|in_valid) && !in_ready && !flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // The storage array has no reset. An entry is only read after it has
    // been written, because count guards every read.
    always_ff @(posedge clk) begin
        for (int l = 0; l < IN_LANES; l++) begin
            if (accept && in_valid[l] && (pos[l] >= byp_n)) begin
                ptr_mem[tail_q + PW'(pos[l] - byp_n)] <= in_ptr[l*AL_IDX_W +: AL_IDX_W];
                st_mem[tail_q + PW'(pos[l] - byp_n)]  <= in_state[l*STATE_W +: STATE_W];
            end
        end
    end

    assign count   = count_q;
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_exec_state_writeback_buffer.sv
module tb_exec_state_writeback_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [3:0]  in_valid;
    logic [23:0] in_ptr;
    logic [15:0] in_state;
    logic        in_ready;
    logic [1:0]  wr_valid;
    logic [11:0] wr_ptr;
    logic [7:0]  wr_state;
    logic [3:0]  count;
    logic        ovf_err;

    exec_state_writeback_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ptr   (in_ptr),
        .in_state (in_state),
        .in_ready (in_ready),
        .wr_valid (wr_valid),
        .wr_ptr   (wr_ptr),
        .wr_state (wr_state),
        .count    (count),
        .ovf_err  (ovf_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q[$];   // {ptr, state}, oldest first
    logic [5:0] lane_p [4];
    logic [3:0] lane_s [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The state value is derived from the pointer so every entry is distinct.
    task automatic set_lanes(input logic [5:0] p0, input logic [5:0] p1,
                             input logic [5:0] p2, input logic [5:0] p3);
        lane_p[0] = p0; lane_p[1] = p1; lane_p[2] = p2; lane_p[3] = p3;
        for (int l = 0; l < 4; l++) lane_s[l] = lane_p[l][3:0] ^ 4'hA;
    endtask

    // Drive lanes; push onto the scoreboard only when the offer is expected to be taken.
    task automatic apply(input logic [3:0] v, input bit push);
        in_valid = v;
        for (int l = 0; l < 4; l++) begin
            in_ptr[l*6 +: 6]   = lane_p[l];
            in_state[l*4 +: 4] = lane_s[l];
            if (push && v[l]) exp_q.push_back({lane_p[l], lane_s[l]});
        end
    endtask

    task automatic idle();
        in_valid = 4'h0;
    endtask

    // Expect n writes this cycle, matched oldest-first against the queue.
    task automatic expect_writes(input int n);
        logic [9:0] e;
        check("wr_valid", {30'd0, wr_valid}, (n == 0) ? 32'd0 : (n == 1) ? 32'd1 : 32'd3);
        for (int k = 0; k < n; k++) begin
            check("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_ptr", {26'd0, wr_ptr[k*6 +: 6]}, {26'd0, e[9:4]});
                check("wr_state", {28'd0, wr_state[k*4 +: 4]}, {28'd0, e[3:0]});
            end
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 4'h0; in_ptr = '0; in_state = '0;
        set_lanes(6'd0, 6'd0, 6'd0, 6'd0);
        #12;
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_wr_valid", {30'd0, wr_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_ovf", {31'd0, ovf_err}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Lanes 1 and 3 on an empty FIFO: written the next cycle, in order.
        set_lanes(6'd0, 6'd7, 6'd0, 6'd9);
        apply(4'b1010, 1'b1);
        expect_writes(0);
        tick();
        idle();
        check("t2_count", {28'd0, count}, 32'd2);
        expect_writes(2);
        tick();
        check("t2_count_drained", {28'd0, count}, 32'd0);
        expect_writes(0);

        // Flush with six entries buffered, plus two new offers.
        set_lanes(6'd40, 6'd41, 6'd42, 6'd43);
        apply(4'hF, 1'b0);
        tick();
        set_lanes(6'd44, 6'd45, 6'd46, 6'd47);
        apply(4'hF, 1'b0);
        tick();
        check("t5_count6", {28'd0, count}, 32'd6);
        set_lanes(6'd50, 6'd51, 6'd0, 6'd0);
        apply(4'b0011, 1'b0);
        flush = 1'b1;
        #1;
        check("t5_flush_wr_valid", {30'd0, wr_valid}, 32'd0);
        tick();
        flush = 1'b0;
        idle();
        check("t5_count", {28'd0, count}, 32'd0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        check("t5_no_ovf", {31'd0, ovf_err}, 32'd0);
        expect_writes(0);
        tick();
        expect_writes(0);

        // Index wrap: three bursts of three, starting at index 60.
        set_lanes(6'd60, 6'd61, 6'd62, 6'd0);
        apply(4'b0111, 1'b1);
        expect_writes(0);
        tick();
        check("t6_count_a", {28'd0, count}, 32'd3);
        expect_writes(2);
        set_lanes(6'd63, 6'd0, 6'd1, 6'd0);
        apply(4'b0111, 1'b1);
        tick();
        check("t6_count_b", {28'd0, count}, 32'd4);
        expect_writes(2);
        set_lanes(6'd2, 6'd3, 6'd4, 6'd0);
        apply(4'b0111, 1'b1);
        tick();
        idle();
        check("t6_count_c", {28'd0, count}, 32'd5);
        expect_writes(2);
        tick();
        check("t6_count_d", {28'd0, count}, 32'd3);
        expect_writes(2);
        tick();
        check("t6_count_e", {28'd0, count}, 32'd1);
        expect_writes(1);
        tick();
        check("t6_count_f", {28'd0, count}, 32'd0);
        expect_writes(0);
        check("t6_sb_empty", exp_q.size(), 32'd0);

        // Four reports per cycle; the third burst arrives while full.
        set_lanes(6'd10, 6'd11, 6'd12, 6'd13);
        apply(4'hF, 1'b1);
        tick();
        check("t3_count_a", {28'd0, count}, 32'd4);
        check("t3_ready_a", {31'd0, in_ready}, 32'd1);
        expect_writes(2);
        set_lanes(6'd14, 6'd15, 6'd16, 6'd17);
        apply(4'hF, 1'b1);
        tick();
        check("t3_count_b", {28'd0, count}, 32'd6);
        check("t3_ready_b", {31'd0, in_ready}, 32'd0);
        expect_writes(2);
        set_lanes(6'd18, 6'd19, 6'd20, 6'd21);
        apply(4'hF, 1'b0);
        tick();
        idle();
        check("t3_count_c", {28'd0, count}, 32'd4);
        check("t4_ovf", {31'd0, ovf_err}, 32'd1);
        expect_writes(2);
        tick();
        expect_writes(2);
        tick();
        check("t3_count_d", {28'd0, count}, 32'd0);
        expect_writes(0);
        check("t4_ovf_sticky", {31'd0, ovf_err}, 32'd1);
        check("t3_sb_empty", exp_q.size(), 32'd0);

        // Reset mid-run with five entries buffered.
        set_lanes(6'd20, 6'd21, 6'd22, 6'd23);
        apply(4'hF, 1'b1);
        tick();
        expect_writes(2);
        set_lanes(6'd24, 6'd25, 6'd26, 6'd0);
        apply(4'b0111, 1'b1);
        tick();
        idle();
        check("t1_count5", {28'd0, count}, 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check("t1_count", {28'd0, count}, 32'd0);
        check("t1_wr_valid", {30'd0, wr_valid}, 32'd0);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        check("t1_ovf", {31'd0, ovf_err}, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();
        check("t1_count_after", {28'd0, count}, 32'd0);

`ifdef EXEC_STATE_BYPASS_EN
        // Bypass: two reports on an empty FIFO are written in the same cycle.
        set_lanes(6'd33, 6'd0, 6'd35, 6'd0);
        apply(4'b0101, 1'b1);
        #1;
        expect_writes(2);
        tick();
        idle();
        check("t7_count", {28'd0, count}, 32'd0);
        expect_writes(0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
